cmd_loader_resp: RTL and testbench
==================================

Name: cmd_loader_resp

Overview:
- Responder end of the host byte-command interface (cmd / cmd_valid / address / data_in → cmd_done / data_out).
- The host uses this interface to load program bytes before raising start_signal.
- The block owns a byte-addressable program RAM and executes one command per cmd_valid assertion.
- It serves big-endian 32-bit instruction fetches to the core.

Parameters:
- DEPTH, 256, program RAM size in bytes; power of two, 4..256.
- ADDR_W, 8, width of address and fetch_addr.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd  in  8  command code: 0 NOP, 1 READ, 2 WRITE, 3 CLEAR; others illegal.
- cmd_valid  in  1  level request from host, held several cycles.
- address  in  ADDR_W  byte address for READ/WRITE.
- data_in  in  8  WRITE data.
- start_signal  in  1  core run enable; when high, memory is locked against writes.
- cmd_done  out  1  one-cycle completion pulse.
- cmd_err  out  1  valid with cmd_done; command rejected.
- data_out  out  8  READ result; held until the next command completes.
- busy  out  1  high from command accept until the state returns to IDLE.
- fetch_addr  in  ADDR_W  core byte address of the instruction.
- fetch_data  out  32  instruction word, registered.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state←IDLE.
  - cmd_done, cmd_err, busy, data_out, fetch_data, clear counter all ←0.
  - RAM contents are not reset.
  - Reset during any state aborts the operation. A CLEAR in progress leaves RAM partially zeroed.
- FSM states: IDLE, EXEC, CLR, DONE, RELEASE.
- IDLE:
  - Accepts on a cmd_valid rising edge: cmd_valid=1 and the registered prior cmd_valid=0.
  - Latches cmd, address, data_in; goes to EXEC; busy=1.
  - A level held high is never re-accepted.
- EXEC (1 cycle):
  - WRITE: mem[address]←data_in. Rejected with cmd_err=1 if start_signal=1 or address≥DEPTH; RAM unchanged.
  - READ: data_out←mem[address]. If address≥DEPTH, data_out←0 and cmd_err=1. Allowed while start_signal=1.
  - NOP: no effect.
  - Illegal code: cmd_err=1.
  - CLEAR: if start_signal=1, reject with cmd_err=1. Otherwise counter←0 and go to CLR.
  - All commands other than CLEAR go to DONE.
- CLR:
  - Writes mem[counter]←0 and counter++ each cycle.
  - After writing DEPTH-1, goes to DONE. CLEAR takes DEPTH cycles.
- DONE:
  - cmd_done=1 for exactly one cycle; cmd_err is valid the same cycle.
  - Then goes to RELEASE.
- RELEASE:
  - Waits for cmd_valid=0, then goes to IDLE and busy=0.
  - If cmd_valid is already low, IDLE is reached the next cycle.
- Latency: rising edge sampled at edge N → cmd_done high during cycle N+2, for single-byte commands.
- cmd_err is cleared at the next command accept.
- Fetch port:
  - Each cycle, fetch_data←{mem[a], mem[a+1], mem[a+2], mem[a+3]} with a=fetch_addr.
  - Indices wrap mod DEPTH; byte at the lowest address is the MSB.
  - Latency is 1 cycle, independent of the FSM.
- Host WRITE and fetch of the same byte in the same cycle: fetch returns the old byte (read-before-write).
- start_signal transitions mid-command: the value sampled in EXEC decides accept/reject.

Test Plan:
- rst, then WRITE 0x00,0x50,0x01,0x13 to addresses 0..3, each cmd_valid held 5 cycles with 7 idle cycles between; then fetch_addr=0.
  → four cmd_done pulses, each 1 cycle wide, at accept+2; cmd_err=0; fetch_data=0x00500113 one cycle later.
- cmd_valid held high 20 cycles with cmd=2, address=5, data_in=0xAA.
  → exactly one cmd_done; READ 5 then gives data_out=0xAA.
- start_signal=1, then WRITE address 4 data 0x77.
  → cmd_done with cmd_err=1; READ 4 returns the prior value; READ while locked has cmd_err=0.
- start_signal=0, CLEAR with DEPTH=256.
  → busy high ~258 cycles; cmd_done after 256 CLR cycles; READ 0 and READ 255 return 0x00; fetch_data=0x00000000.
- cmd=7.
  → cmd_done with cmd_err=1, no RAM change.
- fetch_addr=254 with bytes 254,255,0,1 = 0x11,0x22,0x33,0x44.
  → fetch_data=0x11223344 (wrap).
- rst asserted in the 3rd CLR cycle.
  → outputs 0 next cycle, no cmd_done; bytes 0..2 are 0, byte 3 unchanged.

Source files
------------

// File: rtl/cmd_loader_resp.sv
// Host byte-command responder: owns the byte-addressable program RAM, executes
// NOP/READ/WRITE/CLEAR commands from the host, and serves big-endian 32-bit
// instruction fetches to the core.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a cmd_valid rising edge
// EXEC    | one-cycle execution of the latched command
// CLR     | zeroing the RAM one byte per cycle (CLEAR only)
// DONE    | cmd_done / cmd_err presented on the next cycle
// RELEASE | waiting for the host to drop cmd_valid
module cmd_loader_resp #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        cmd,
  input  logic              cmd_valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        data_in,
  input  logic              start_signal,
  output logic              cmd_done,
  output logic              cmd_err,
  output logic [7:0]        data_out,
  output logic              busy,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [7:0] CMD_NOP   = 8'd0;
  localparam logic [7:0] CMD_READ  = 8'd1;
  localparam logic [7:0] CMD_WRITE = 8'd2;
  localparam logic [7:0] CMD_CLEAR = 8'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_CLR,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t            state_q;
  logic              cv_q;
  logic [7:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [IDX_W-1:0]  ctr_q;
  logic              cmd_done_q;
  logic              cmd_err_q;
  logic [7:0]        data_out_q;
  logic              busy_q;
  logic [31:0]       fetch_q;

  logic [7:0]        mem [DEPTH];

  logic              addr_ok;
  logic [IDX_W-1:0]  addr_idx;
  logic              mem_we_d;
  logic [IDX_W-1:0]  mem_waddr_d;
  logic [7:0]        mem_wdata_d;
  logic [ADDR_W-1:0] fa1, fa2, fa3;

  assign addr_ok  = ({1'b0, addr_q} < DEPTH_W);
  assign addr_idx = addr_q[IDX_W-1:0];

  // Byte addresses of the fetch word; masking to the index width wraps mod DEPTH.
  assign fa1 = fetch_addr + ADDR_W'(1);
  assign fa2 = fetch_addr + ADDR_W'(2);
  assign fa3 = fetch_addr + ADDR_W'(3);

  // Single RAM write port shared by host WRITE (EXEC) and the CLEAR sweep (CLR).
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = addr_idx;
    mem_wdata_d = wdata_q;
    if (state_q == S_EXEC && cmd_q == CMD_WRITE && !start_signal && addr_ok) begin
      mem_we_d = 1'b1;
    end else if (state_q == S_CLR) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = ctr_q;
      mem_wdata_d = 8'h00;
    end
  end

  // RAM storage; deliberately not reset so an aborted CLEAR keeps what it zeroed.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem[mem_waddr_d] <= mem_wdata_d;
    end
  end

  // Command FSM with registered host-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cv_q       <= 1'b0;
      cmd_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ctr_q      <= '0;
      cmd_done_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      cv_q       <= cmd_valid;
      cmd_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && !cv_q) begin
            cmd_q     <= cmd;
            addr_q    <= address;
            wdata_q   <= data_in;
            cmd_err_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_EXEC;
          end
        end
        S_EXEC: begin
          state_q <= S_DONE;
          case (cmd_q)
            CMD_NOP: begin
            end
            CMD_READ: begin
              if (addr_ok) begin
                data_out_q <= mem[addr_idx];
              end else begin
                data_out_q <= 8'h00;
                cmd_err_q  <= 1'b1;
              end
            end
            CMD_WRITE: begin
              if (start_signal || !addr_ok) begin
                cmd_err_q <= 1'b1;
              end
            end
            CMD_CLEAR: begin
              if (start_signal) begin
                cmd_err_q <= 1'b1;
              end else begin
                ctr_q   <= '0;
                state_q <= S_CLR;
              end
            end
            default: cmd_err_q <= 1'b1;
          endcase
        end
        S_CLR: begin
          ctr_q <= ctr_q + IDX_W'(1);
          if (ctr_q == LAST_IDX) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          cmd_done_q <= 1'b1;
          state_q    <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!cmd_valid) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Instruction fetch: registered big-endian word, read-before-write against the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= '0;
    end else begin
      fetch_q <= {mem[fetch_addr[IDX_W-1:0]], mem[fa1[IDX_W-1:0]],
                  mem[fa2[IDX_W-1:0]], mem[fa3[IDX_W-1:0]]};
    end
  end

  assign cmd_done   = cmd_done_q;
  assign cmd_err    = cmd_err_q;
  assign data_out   = data_out_q;
  assign busy       = busy_q;
  assign fetch_data = fetch_q;

endmodule

// File: tb/tb_cmd_loader_resp.sv
// Scoreboard bench for cmd_loader_resp: the stimulus thread predicts each
// command's response from a byte-array RAM model and queues it; a monitor
// pops and compares on every cmd_done pulse.
module tb_cmd_loader_resp;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        cmd = '0;
  logic              cmd_valid = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [7:0]        data_in = '0;
  logic              start_signal = 1'b0;
  logic              cmd_done;
  logic              cmd_err;
  logic [7:0]        data_out;
  logic              busy;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic [31:0]       fetch_data;

  cmd_loader_resp #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid), .address(address),
    .data_in(data_in), .start_signal(start_signal), .cmd_done(cmd_done),
    .cmd_err(cmd_err), .data_out(data_out), .busy(busy),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         lat;
    int         acc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_mem [DEPTH];
  logic [7:0] model_dout = 8'h00;
  int         checks = 0;
  int         errors = 0;
  bit         prev_done = 1'b0;

  // Monitor: every cmd_done pulse must match the oldest predicted response.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (cmd_done) begin
        exp_t e;
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_width: cmd_done high two cycles in a row at cycle %0d", cyc);
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: cmd_done at cycle %0d with no command pending", cyc);
        end else begin
          e = exp_q.pop_front();
          checks += 4;
          if (cmd_err !== e.err) begin
            errors++;
            $display("FAIL done_err: got %0b, want %0b (cycle %0d)", cmd_err, e.err, cyc);
          end
          if (data_out !== e.data) begin
            errors++;
            $display("FAIL done_data: got %02h, want %02h (cycle %0d)", data_out, e.data, cyc);
          end
          if (cyc - e.acc != e.lat) begin
            errors++;
            $display("FAIL done_latency: got %0d cycles, want %0d", cyc - e.acc, e.lat);
          end
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL done_busy: busy got %0b, want 1 at cmd_done", busy);
          end
        end
      end
      prev_done = cmd_done;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d, want busy=0 pending=0", busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                        input int hold);
    exp_t e;
    int ai;
    @(negedge clk);
    cmd = c; address = a; data_in = d; cmd_valid = 1'b1;
    ai = int'(a);
    e.acc = cyc + 1;
    e.err = 1'b0;
    e.lat = 2;
    case (c)
      8'd0: begin end
      8'd1: begin
        if (ai < DEPTH) model_dout = model_mem[ai];
        else begin model_dout = 8'h00; e.err = 1'b1; end
      end
      8'd2: begin
        if (start_signal || ai >= DEPTH) e.err = 1'b1;
        else model_mem[ai] = d;
      end
      8'd3: begin
        if (start_signal) e.err = 1'b1;
        else begin
          for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
          e.lat = DEPTH + 2;
        end
      end
      default: e.err = 1'b1;
    endcase
    e.data = model_dout;
    exp_q.push_back(e);
    repeat (hold) @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();
  endtask

  task automatic check_fetch(input logic [7:0] a);
    logic [31:0] want;
    int ai;
    @(negedge clk);
    fetch_addr = a;
    @(negedge clk);
    ai = int'(a);
    want = {model_mem[ai], model_mem[(ai + 1) % DEPTH],
            model_mem[(ai + 2) % DEPTH], model_mem[(ai + 3) % DEPTH]};
    checks++;
    if (fetch_data !== want) begin
      errors++;
      $display("FAIL fetch_%02h: got %08h, want %08h", a, fetch_data, want);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if ({busy, cmd_done, cmd_err} !== 3'b000 || data_out !== 8'h00 || fetch_data !== 32'h0) begin
      errors++;
      $display("FAIL %s: busy=%0b done=%0b err=%0b dout=%02h fetch=%08h, want all 0",
               tag, busy, cmd_done, cmd_err, data_out, fetch_data);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c, a, d;
    int r;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_state");
    rst = 1'b0;

    // Program load: four writes, held 5 cycles, 7 idle cycles between.
    do_cmd(8'd2, 8'd0, 8'h00, 5); repeat (7) @(negedge clk);
    do_cmd(8'd2, 8'd1, 8'h50, 5); repeat (7) @(negedge clk);
    do_cmd(8'd2, 8'd2, 8'h01, 5); repeat (7) @(negedge clk);
    do_cmd(8'd2, 8'd3, 8'h13, 5); repeat (7) @(negedge clk);
    check_fetch(8'd0);

    // Long held level must be accepted exactly once.
    do_cmd(8'd2, 8'd5, 8'hAA, 20);
    do_cmd(8'd1, 8'd5, 8'h00, 3);

    // Locked memory: write rejected, reads still allowed.
    do_cmd(8'd2, 8'd4, 8'h3C, 2);
    @(negedge clk); start_signal = 1'b1;
    do_cmd(8'd2, 8'd4, 8'h77, 3);
    do_cmd(8'd1, 8'd4, 8'h00, 3);
    do_cmd(8'd3, 8'd0, 8'h00, 2);
    @(negedge clk); start_signal = 1'b0;

    // Full clear.
    do_cmd(8'd3, 8'd0, 8'h00, 5);
    do_cmd(8'd1, 8'd0, 8'h00, 2);
    do_cmd(8'd1, 8'd255, 8'h00, 2);
    check_fetch(8'd0);

    // Illegal command leaves RAM untouched.
    do_cmd(8'd2, 8'd9, 8'h5E, 2);
    do_cmd(8'd7, 8'd9, 8'hFF, 2);
    do_cmd(8'd1, 8'd9, 8'h00, 2);

    // Fetch wrap across the top of the RAM.
    do_cmd(8'd2, 8'd254, 8'h11, 1);
    do_cmd(8'd2, 8'd255, 8'h22, 1);
    do_cmd(8'd2, 8'd0, 8'h33, 1);
    do_cmd(8'd2, 8'd1, 8'h44, 1);
    check_fetch(8'd254);

    // Reset during the third CLR cycle: bytes 0..2 zeroed, byte 3 kept.
    do_cmd(8'd2, 8'd3, 8'h5A, 2);
    @(negedge clk);
    cmd = 8'd3; cmd_valid = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset_in_clr");
    for (int i = 0; i < 3; i++) model_mem[i] = 8'h00;
    model_dout = 8'h00;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) do_cmd(8'd1, 8'(i), 8'h00, 2);
    check_fetch(8'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      c = 8'd1;
      else if (r < 70) c = 8'd2;
      else if (r < 80) c = 8'd0;
      else if (r < 84) c = 8'd3;
      else             c = 8'($urandom_range(4, 255));
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      @(negedge clk);
      start_signal = ($urandom_range(0, 3) == 0);
      do_cmd(c, a, d, $urandom_range(1, 6));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      check_fetch(8'($urandom_range(0, 255)));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
